iomem_gpio_pwm: RTL and testbench
=================================

# iomem_gpio_pwm

Parametrised GPIO/LED peripheral on the PicoSoC `iomem` bus, the successor to the fixed 32-bit GPIO register in the board top level. It provides up to 32 channels, each with:
- per-pin output enable,
- atomic set/clear/toggle writes,
- a synchronised input readback,
- an optional per-channel PWM generator with glitch-free duty updates (for LED dimming).

It sits in the board top, between the SoC `iomem_*` port and the LED/SB_IO pins.

## Interface
Parameters:
- `NUM_CH`, 8: number of channels, 1..32.
- `PWM_BITS`, 8: PWM counter and duty width, 4..16.
- `BASE_ADDR`, 8'h03: value of `iomem_addr[31:24]` that selects this block.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: single-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `gpio_out` out NUM_CH: pin output values (registered).
- `gpio_oe` out NUM_CH: pin output enables (registered).
- `gpio_in` in NUM_CH: asynchronous pin inputs.

## Operation
- Select: `iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR`. Offset is `iomem_addr[7:0]`; `addr[1:0]` is ignored. Bits at and above NUM_CH read 0 and ignore writes.
- Register map (reset value 0 for all):
  - 0x00 OUT (RW): output data.
  - 0x04 SET (W): OUT |= wdata.
  - 0x08 CLR (W): OUT &= ~wdata.
  - 0x0C TGL (W): OUT ^= wdata.
  - 0x10 DIR (RW): drives `gpio_oe`.
  - 0x14 IN (RO): 2-flop-synchronised `gpio_in`.
  - 0x18 PWM_EN (RW): per-channel PWM mode.
  - 0x1C PRESCALE (RW, 16 bits): PWM tick every PRESCALE+1 cycles.
  - 0x40+4·i DUTY[i] (RW, PWM_BITS bits): i < NUM_CH.
- RW registers honour byte strobes per lane. SET/CLR/TGL apply only to bits in strobed lanes. Reads of SET/CLR/TGL return 0.
- Unmapped offset: acknowledged normally, rdata=0, write discarded.
- PWM:
  - The prescaler counts 0..PRESCALE. Each wrap is a tick, which increments `pwm_cnt` (PWM_BITS wide, wraps 2^PWM_BITS−1 → 0).
  - Each DUTY[i] has a shadow register, loaded from DUTY[i] on the tick where `pwm_cnt` wraps to 0 and also loaded by reset.
  - Channel output in PWM mode is `pwm_cnt < shadow[i]`. Duty 0 gives constant 0; duty 2^PWM_BITS−1 gives low for exactly 1 of 2^PWM_BITS counts.
- `gpio_out[i]` is `PWM_EN[i] ? pwm_o[i] : OUT[i]`, registered. `gpio_oe` is DIR, registered. OUT keeps its value while PWM is enabled.
- A write to PRESCALE resets the prescaler count to 0; `pwm_cnt` is unaffected.

## Timing
- Request sampled at edge N. At edge N+1: `iomem_ready`=1 for exactly one cycle, rdata is valid, and the register is updated. Readback returns pre-write contents.
- `gpio_out` and `gpio_oe` reflect a register write at edge N+2.
- `gpio_in` reaches IN after 2 edges; a read returns IN as of edge N.
- A back-to-back request with `iomem_valid` held high is accepted every other cycle (ready, idle, ready…).
- A duty write becomes effective at the next `pwm_cnt` wrap, never mid-period. Two writes within one period: the last one wins.
- PWM period is (PRESCALE+1)·2^PWM_BITS cycles.
- Reset behaviour:
  - `reset` high at any edge clears all registers, shadows, counters, synchronisers, `iomem_ready` and `iomem_rdata`.
  - `gpio_out` and `gpio_oe` are 0 from the first edge with reset high.
  - A transaction in flight when reset asserts is dropped, with no ready.
- Requests with a non-matching BASE_ADDR are never acknowledged and have no effect.

## Test plan
- **Byte-strobed write/read:** write OUT=0xA5, wstrb=4'b0001, NUM_CH=8 → ready exactly one cycle at N+1, `gpio_out`=8'hA5 at N+2; read 0x00 → 0x000000A5.
- **Atomic writes:** OUT=0xF0, SET 0x0F, CLR 0x30, TGL 0x81 → OUT=0x4E. Write OUT=0xFFFFFFFF with NUM_CH=8 → read 0x000000FF.
- **PWM waveform:** PWM_BITS=4, PRESCALE=0, PWM_EN[0]=1, DUTY[0]=5 → `gpio_out[0]` high 5 of every 16 cycles. DUTY 0 → always low. DUTY 15 → low 1 of 16 cycles.
- **Glitch-free duty update:** PRESCALE=3, DUTY 8, then write DUTY 2 mid-period → the current period keeps 32 high cycles; the next period has 8.
- **Input synchronisation:** toggle `gpio_in[3]` → IN bit 3 changes exactly 2 edges later. Read offset 0x30 → 0 and ready. Non-matching address → no ready.
- **Reset mid-PWM:** assert `reset` mid-PWM with a pending request → all outputs 0 the next edge, no ready. After release, every register reads 0.

Source files
------------

// File: rtl/iomem_gpio_pwm_if.sv
// iomem_gpio_pwm_if: PicoSoC iomem bus bundle for the GPIO/PWM peripheral.
// Signals:
//   iomem_valid  request from the SoC
//   iomem_ready  single-cycle acknowledge from the peripheral
//   iomem_wstrb  byte write strobes, all-zero means read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
interface iomem_gpio_pwm_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_gpio_pwm.sv
// iomem_gpio_pwm: GPIO/LED peripheral on the PicoSoC iomem bus.
// Up to 32 channels with output enable, atomic set/clear/toggle, synchronised
// input readback and a per-channel PWM generator with shadowed duty values.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   bus       iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//   gpio_out  registered pin values (PWM or OUT per channel)
//   gpio_oe   registered pin output enables (DIR)
//   gpio_in   asynchronous pin inputs
module iomem_gpio_pwm #(
  parameter int         NUM_CH    = 8,
  parameter int         PWM_BITS  = 8,
  parameter logic [7:0] BASE_ADDR = 8'h03
) (
  input  logic               clk,
  input  logic               reset,
  iomem_gpio_pwm_if.slave    bus,
  output logic [NUM_CH-1:0]  gpio_out,
  output logic [NUM_CH-1:0]  gpio_oe,
  input  logic [NUM_CH-1:0]  gpio_in
);

  // Word offsets (iomem_addr[7:2]) of the register map
  localparam logic [5:0] W_OUT      = 6'd0;
  localparam logic [5:0] W_SET      = 6'd1;
  localparam logic [5:0] W_CLR      = 6'd2;
  localparam logic [5:0] W_TGL      = 6'd3;
  localparam logic [5:0] W_DIR      = 6'd4;
  localparam logic [5:0] W_IN       = 6'd5;
  localparam logic [5:0] W_PWM_EN   = 6'd6;
  localparam logic [5:0] W_PRESCALE = 6'd7;
  localparam logic [5:0] W_DUTY0    = 6'd16;

  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]   out_r, dir_r, pwm_en_r, sync1_r, in_r;
  logic [NUM_CH-1:0]   pwm_o_s;
  logic [15:0]         prescale_r, presc_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] duty_r   [NUM_CH];
  logic [PWM_BITS-1:0] shadow_r [NUM_CH];
  logic                ready_r;
  logic [31:0]         rdata_r, rdata_s;
  logic [31:0]         wmask_s, wbits_s;
  logic                sel_s, wr_s, presc_wr_s, tick_s, wrap_s;
  logic [5:0]          word_s;
  logic                unused_s;

  // The !ready_r term makes a held request acknowledge every other cycle
  assign sel_s      = bus.iomem_valid && !ready_r &&
                      (bus.iomem_addr[31:24] == BASE_ADDR);
  assign wr_s       = sel_s && (bus.iomem_wstrb != 4'b0000);
  assign word_s     = bus.iomem_addr[7:2];
  assign presc_wr_s = wr_s && (word_s == W_PRESCALE);
  assign wmask_s    = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                       {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
  assign wbits_s    = bus.iomem_wdata & wmask_s;

  assign bus.iomem_ready = ready_r;
  assign bus.iomem_rdata = rdata_r;

  // Address bits outside the decode and mask bits beyond the widest register
  assign unused_s = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0], wmask_s, wbits_s};

  assign tick_s = (presc_cnt_r == prescale_r);
  assign wrap_s = tick_s && (pwm_cnt_r == PWM_MAX);

  // Read multiplexer; write-only and unmapped offsets read as zero
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (word_s)
      W_OUT:      rdata_s = 32'(out_r);
      W_DIR:      rdata_s = 32'(dir_r);
      W_IN:       rdata_s = 32'(in_r);
      W_PWM_EN:   rdata_s = 32'(pwm_en_r);
      W_PRESCALE: rdata_s = 32'(prescale_r);
      default:    rdata_s = 32'h0000_0000;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_s = rdata_s | ({32{word_s == (W_DUTY0 + 6'(i))}} & 32'(duty_r[i]));
    end
  end

  // Bus acknowledge, read data capture and control register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r    <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      out_r      <= {NUM_CH{1'b0}};
      dir_r      <= {NUM_CH{1'b0}};
      pwm_en_r   <= {NUM_CH{1'b0}};
      prescale_r <= 16'h0000;
    end else begin
      ready_r <= sel_s;
      rdata_r <= sel_s ? rdata_s : 32'h0000_0000;
      if (wr_s) begin
        case (word_s)
          W_OUT:      out_r      <= (out_r & ~wmask_s[NUM_CH-1:0]) | wbits_s[NUM_CH-1:0];
          W_SET:      out_r      <= out_r | wbits_s[NUM_CH-1:0];
          W_CLR:      out_r      <= out_r & ~wbits_s[NUM_CH-1:0];
          W_TGL:      out_r      <= out_r ^ wbits_s[NUM_CH-1:0];
          W_DIR:      dir_r      <= (dir_r & ~wmask_s[NUM_CH-1:0]) | wbits_s[NUM_CH-1:0];
          W_PWM_EN:   pwm_en_r   <= (pwm_en_r & ~wmask_s[NUM_CH-1:0]) | wbits_s[NUM_CH-1:0];
          W_PRESCALE: prescale_r <= (prescale_r & ~wmask_s[15:0]) | wbits_s[15:0];
          default:    out_r      <= out_r;
        endcase
      end
    end
  end

  // Duty registers (bus side) and their shadows, loaded only at a period wrap
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        duty_r[i]   <= {PWM_BITS{1'b0}};
        shadow_r[i] <= {PWM_BITS{1'b0}};
      end else begin
        if (wr_s && (word_s == (W_DUTY0 + 6'(i)))) begin
          duty_r[i] <= (duty_r[i] & ~wmask_s[PWM_BITS-1:0]) | wbits_s[PWM_BITS-1:0];
        end
        if (wrap_s) begin
          shadow_r[i] <= duty_r[i];
        end
      end
    end
  end

  // Prescaler and PWM period counter; a PRESCALE write restarts the prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_r <= 16'h0000;
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
    end else begin
      if (presc_wr_s || tick_s) begin
        presc_cnt_r <= 16'h0000;
      end else begin
        presc_cnt_r <= presc_cnt_r + 16'd1;
      end
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      end
    end
  end

  // PWM compare against the shadow so duty changes never cut a period short
  always_comb begin
    pwm_o_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_o_s[i] = (pwm_cnt_r < shadow_r[i]);
    end
  end

  // Two-flop input synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {NUM_CH{1'b0}};
      in_r    <= {NUM_CH{1'b0}};
    end else begin
      sync1_r <= gpio_in;
      in_r    <= sync1_r;
    end
  end

  // Registered pin drivers; OUT is retained underneath PWM mode
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= {NUM_CH{1'b0}};
      gpio_oe  <= {NUM_CH{1'b0}};
    end else begin
      gpio_out <= (pwm_en_r & pwm_o_s) | (~pwm_en_r & out_r);
      gpio_oe  <= dir_r;
    end
  end

endmodule

// File: tb/tb_iomem_gpio_pwm.sv
// tb_iomem_gpio_pwm: directed self-checking bench for iomem_gpio_pwm
// (NUM_CH=8, PWM_BITS=4). Read expectations go through a scoreboard queue.
module tb_iomem_gpio_pwm;
  localparam int NUM_CH   = 8;
  localparam int PWM_BITS = 4;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] gpio_out, gpio_oe, gpio_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc    = 0;
  int hi_cnt = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  iomem_gpio_pwm_if bus ();

  iomem_gpio_pwm #(
    .NUM_CH   (NUM_CH),
    .PWM_BITS (PWM_BITS),
    .BASE_ADDR(8'h03)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .gpio_in (gpio_in)
  );

  always #5 clk = ~clk;

  // cycle and gpio_out[0] high-sample counters
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (gpio_out[0]) hi_cnt <= hi_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ra(input logic [7:0] off);
    return {8'h03, 16'h0000, off};
  endfunction

  // Starts at a negedge, returns at the negedge after the acknowledge
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int lat);
    logic [31:0] e;
    string       t;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = a;
    bus.iomem_wdata = d;
    bus.iomem_wstrb = s;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.iomem_ready && lat < 8);
    check("ack", {31'd0, bus.iomem_ready}, 32'd1);
    if (s == 4'b0000 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.iomem_rdata, e);
    end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    int lat;
    xfer(ra(off), d, s, lat);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] e, input string t);
    int lat;
    exp_q.push_back(e);
    tag_q.push_back(t);
    xfer(ra(off), 32'h0000_0000, 4'b0000, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_hi(input int n, output int hi);
    int h0;
    h0 = hi_cnt;
    repeat (n) @(negedge clk);
    hi = hi_cnt - h0;
  endtask

  initial begin
    int          lat, hi, c0, cy0, nrdy;
    logic [5:0]  pat;
    logic        prev, found;

    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0000_0000;
    bus.iomem_wdata = 32'h0000_0000;
    bus.iomem_wstrb = 4'b0000;
    gpio_in         = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst_ready", {31'd0, bus.iomem_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // byte-strobed write: ready after one edge, pins one edge later
    xfer(ra(8'h00), 32'h0000_00A5, 4'b0001, lat);
    check("wr_latency", 32'(lat), 32'd1);
    check("gpio_out_before", 32'(gpio_out), 32'd0);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, bus.iomem_ready}, 32'd0);
    check("gpio_out_after", 32'(gpio_out), 32'h0000_00A5);
    @(negedge clk);
    rd(8'h00, 32'h0000_00A5, "rd_out_a5");
    wr(8'h00, 32'h0000_FFFF, 4'b0010);
    rd(8'h00, 32'h0000_00A5, "out_lane1_ignored");

    // atomic set/clear/toggle
    wr(8'h00, 32'h0000_00F0, 4'b1111);
    wr(8'h04, 32'h0000_000F, 4'b1111);
    wr(8'h08, 32'h0000_0030, 4'b1111);
    wr(8'h0C, 32'h0000_0081, 4'b1111);
    rd(8'h00, 32'h0000_004E, "atomic_result");
    wr(8'h04, 32'h0000_0101, 4'b0010);
    rd(8'h00, 32'h0000_004E, "set_unstrobed_lane");
    rd(8'h04, 32'h0000_0000, "rd_set_zero");
    wr(8'h00, 32'hFFFF_FFFF, 4'b1111);
    rd(8'h00, 32'h0000_00FF, "out_width_clip");

    // DIR drives gpio_oe one edge after the register update
    idle(2);
    wr(8'h10, 32'h0000_003C, 4'b1111);
    check("gpio_oe_before", 32'(gpio_oe), 32'd0);
    @(posedge clk); #1;
    check("gpio_oe_after", 32'(gpio_oe), 32'h0000_003C);
    @(negedge clk);
    rd(8'h10, 32'h0000_003C, "rd_dir");

    // PRESCALE is 16 bits with per-lane strobes, DUTY is PWM_BITS wide
    wr(8'h1C, 32'hABCD_1234, 4'b1111);
    rd(8'h1C, 32'h0000_1234, "prescale_16b");
    wr(8'h1C, 32'h0000_7700, 4'b0010);
    rd(8'h1C, 32'h0000_7734, "prescale_lane1");
    wr(8'h1C, 32'h0000_0000, 4'b1111);
    wr(8'h44, 32'hFFFF_FFFF, 4'b1111);
    rd(8'h44, 32'h0000_000F, "duty1_width");

    // unmapped offsets and a DUTY slot beyond NUM_CH
    wr(8'h30, 32'hFFFF_FFFF, 4'b1111);
    rd(8'h30, 32'h0000_0000, "unmapped_0x30");
    wr(8'h60, 32'hFFFF_FFFF, 4'b1111);
    rd(8'h60, 32'h0000_0000, "duty_beyond_nch");

    // non-matching base: never acknowledged, no effect
    idle(2);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0000;
    bus.iomem_wdata = 32'h0000_0055;
    bus.iomem_wstrb = 4'b1111;
    nrdy = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.iomem_ready) nrdy++;
    end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
    check("foreign_no_ready", 32'(nrdy), 32'd0);
    rd(8'h00, 32'h0000_00FF, "foreign_no_write");

    // held request acknowledged every other cycle
    idle(2);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = ra(8'h00);
    bus.iomem_wstrb = 4'b0000;
    pat = 6'b000000;
    repeat (6) begin
      @(posedge clk); #1;
      pat = {pat[4:0], bus.iomem_ready};
    end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    check("b2b_pattern", 32'(pat), 32'h0000_002A);

    // input synchroniser: IN changes exactly two edges after the pin
    idle(2);
    gpio_in = 8'h08;
    @(negedge clk);
    rd(8'h14, 32'h0000_0000, "in_not_yet");
    rd(8'h14, 32'h0000_0008, "in_set");
    idle(2);
    gpio_in = 8'h00;
    idle(2);
    rd(8'h14, 32'h0000_0000, "in_cleared");

    // PWM waveform, PRESCALE=0, 16-cycle period
    wr(8'h00, 32'h0000_00AA, 4'b1111);
    wr(8'h18, 32'h0000_0001, 4'b1111);
    wr(8'h40, 32'h0000_0005, 4'b1111);
    idle(40);
    check("pwm_other_pins", 32'(gpio_out[7:1]), 32'h0000_0055);
    count_hi(64, hi);
    check("pwm_duty5", 32'(hi), 32'd20);
    wr(8'h40, 32'h0000_0000, 4'b1111);
    idle(40);
    count_hi(64, hi);
    check("pwm_duty0", 32'(hi), 32'd0);
    wr(8'h40, 32'h0000_000F, 4'b1111);
    idle(40);
    count_hi(64, hi);
    check("pwm_duty15", 32'(hi), 32'd60);
    rd(8'h00, 32'h0000_00AA, "out_kept_under_pwm");

    // glitch-free duty update, PRESCALE=3, 64-cycle period
    wr(8'h1C, 32'h0000_0003, 4'b1111);
    wr(8'h40, 32'h0000_0008, 4'b1111);
    idle(200);
    prev  = gpio_out[0];
    found = 1'b0;
    for (int k = 0; k < 140 && !found; k++) begin
      @(negedge clk);
      if (!prev && gpio_out[0]) found = 1'b1;
      else prev = gpio_out[0];
    end
    check("pwm_rise_found", {31'd0, found}, 32'd1);
    c0  = hi_cnt;
    cy0 = cyc;
    wr(8'h40, 32'h0000_0002, 4'b1111);
    while (cyc < cy0 + 64) @(negedge clk);
    check("period_kept_duty8", 32'(hi_cnt - c0), 32'd32);
    c0 = hi_cnt;
    while (cyc < cy0 + 128) @(negedge clk);
    check("next_period_duty2", 32'(hi_cnt - c0), 32'd8);

    // reset with a pending request while PWM runs
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = ra(8'h18);
    bus.iomem_wstrb = 4'b0000;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", {31'd0, bus.iomem_ready}, 32'd0);
    check("rst_mid_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_mid_gpio_oe", 32'(gpio_oe), 32'd0);
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_drop_ready", {31'd0, bus.iomem_ready}, 32'd0);
    @(negedge clk);
    rd(8'h00, 32'h0000_0000, "post_rst_out");
    rd(8'h10, 32'h0000_0000, "post_rst_dir");
    rd(8'h18, 32'h0000_0000, "post_rst_pwm_en");
    rd(8'h1C, 32'h0000_0000, "post_rst_prescale");
    rd(8'h40, 32'h0000_0000, "post_rst_duty0");
    rd(8'h44, 32'h0000_0000, "post_rst_duty1");
    idle(20);
    check("post_rst_gpio_out", 32'(gpio_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
